// File: rtl/decim4_d4_core.sv
// Decimate-by-4 I/Q core: averages groups of 4 FIFO samples (or passes 1 through in bypass).
// Latency: first output written 6 cycles after start (3 in bypass), one output per 6 (3) cycles.
// Backpressure: reads stall while Empty_i is high, writes stall while Afull_i is high.
module decim4_d4_core #(
   parameter int DATAPATH_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      rst_a,
   input  logic                      start,
   input  logic                      Empty_i,
   input  logic                      Afull_i,
   input  logic [31:0]               config_reg,
   input  logic [DATAPATH_WIDTH-1:0] data_in_I,
   input  logic [DATAPATH_WIDTH-1:0] data_in_Q,
   output logic                      Read_Enable_fifo,
   output logic                      Write_Enable_fifo,
   output logic [DATAPATH_WIDTH-1:0] I_dec,
   output logic [DATAPATH_WIDTH-1:0] Q_dec,
   output logic [7:0]                status_reg
);

   localparam int AW = DATAPATH_WIDTH + 2;

   typedef enum logic [1:0] {IDLE, READ, OUT, DONE} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [15:0]               r_num_out;
   logic                      r_bypass;
   logic [15:0]               r_out_cnt;
   logic [2:0]                r_rd_cnt;
   logic [2:0]                r_cap_cnt;
   logic                      r_cap_vld;
   logic [AW-1:0]             r_acc_i;
   logic [AW-1:0]             r_acc_q;
   logic [DATAPATH_WIDTH-1:0] r_i_dec;
   logic [DATAPATH_WIDTH-1:0] r_q_dec;
   logic                      r_done;

   logic                      w_start_acc;
   logic [2:0]                w_k;
   logic                      w_rd_pend;
   logic                      w_rd_en;
   logic                      w_wr_en;
   logic                      w_last_cap;
   logic [15:0]               w_cnt_nxt;
   logic [AW-1:0]             w_sum_i;
   logic [AW-1:0]             w_sum_q;
   logic                      w_unused;

   // Only num_out and bypass are meaningful in the config word.
   assign w_unused    = ^config_reg[31:17];

   assign w_start_acc = (r_state == IDLE) && start;
   assign w_k         = r_bypass ? 3'd1 : 3'd4;
   assign w_rd_pend   = (r_state == READ) && (r_rd_cnt < w_k);
   assign w_rd_en     = w_rd_pend && !Empty_i;
   assign w_wr_en     = (r_state == OUT) && !Afull_i;
   // Captures only happen in READ, so the group-closing capture always lands there.
   assign w_last_cap  = r_cap_vld && (r_cap_cnt == (w_k - 3'd1));
   assign w_cnt_nxt   = r_out_cnt + 16'd1;

   // Sign-extend the sample by two bits; four samples of width W always fit in W+2.
   assign w_sum_i = r_acc_i + {{2{data_in_I[DATAPATH_WIDTH-1]}}, data_in_I};
   assign w_sum_q = r_acc_q + {{2{data_in_Q[DATAPATH_WIDTH-1]}}, data_in_Q};

   assign Read_Enable_fifo  = w_rd_en;
   assign Write_Enable_fifo = w_wr_en;
   assign I_dec             = r_i_dec;
   assign Q_dec             = r_q_dec;
   assign status_reg        = {2'b00, r_bypass, 1'b0,
                               (r_state == OUT) && Afull_i,
                               w_rd_pend && Empty_i,
                               (r_state == READ) || (r_state == OUT),
                               r_done};

   // State register.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode: a run is READ/OUT pairs until num_out writes are done.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = (config_reg[15:0] == 16'd0) ? DONE : READ;
         READ:    if (w_last_cap) w_state_nxt = OUT;
         OUT:     if (w_wr_en) w_state_nxt = (w_cnt_nxt == r_num_out) ? DONE : READ;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: config latch, read/capture counters, accumulation, output registers, done flag.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         r_num_out <= '0;
         r_bypass  <= 1'b0;
         r_out_cnt <= '0;
         r_rd_cnt  <= '0;
         r_cap_cnt <= '0;
         r_cap_vld <= 1'b0;
         r_acc_i   <= '0;
         r_acc_q   <= '0;
         r_i_dec   <= '0;
         r_q_dec   <= '0;
         r_done    <= 1'b0;
      end else begin
         r_cap_vld <= w_rd_en;
         if (w_start_acc) begin
            r_num_out <= config_reg[15:0];
            r_bypass  <= config_reg[16];
            r_out_cnt <= '0;
            r_rd_cnt  <= '0;
            r_cap_cnt <= '0;
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            r_done    <= 1'b0;
         end
         if (w_rd_en) r_rd_cnt <= r_rd_cnt + 3'd1;
         if (r_cap_vld) begin
            if (w_last_cap) begin
               // Taking bits [AW-1:2] is an arithmetic shift right by 2 (floor).
               r_i_dec   <= r_bypass ? data_in_I : w_sum_i[AW-1:2];
               r_q_dec   <= r_bypass ? data_in_Q : w_sum_q[AW-1:2];
               r_acc_i   <= '0;
               r_acc_q   <= '0;
               r_cap_cnt <= '0;
               r_rd_cnt  <= '0;
            end else begin
               r_acc_i   <= w_sum_i;
               r_acc_q   <= w_sum_q;
               r_cap_cnt <= r_cap_cnt + 3'd1;
            end
         end
         if (w_wr_en) r_out_cnt <= w_cnt_nxt;
         if (r_state == DONE) r_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_decim4_d4_core.sv
// Bench for decim4_d4_core: upstream FIFO model, scoreboard of expected decimated samples.
// Latency: checks write cycle numbers relative to the start pulse (cycle 0).
// Backpressure: drives Empty_i / Afull_i stalls and checks stall status and timing.
module tb_decim4_d4_core;

   localparam int W = 12;

   logic          clk        = 1'b0;
   logic          rst_a      = 1'b1;
   logic          start      = 1'b0;
   logic          Empty_i    = 1'b0;
   logic          Afull_i    = 1'b0;
   logic [31:0]   config_reg = '0;
   logic [W-1:0]  data_in_I  = '0;
   logic [W-1:0]  data_in_Q  = '0;
   logic          Read_Enable_fifo;
   logic          Write_Enable_fifo;
   logic [W-1:0]  I_dec;
   logic [W-1:0]  Q_dec;
   logic [7:0]    status_reg;

   decim4_d4_core #(.DATAPATH_WIDTH(W)) dut (
      .clk               (clk),
      .rst_a             (rst_a),
      .start             (start),
      .Empty_i           (Empty_i),
      .Afull_i           (Afull_i),
      .config_reg        (config_reg),
      .data_in_I         (data_in_I),
      .data_in_Q         (data_in_Q),
      .Read_Enable_fifo  (Read_Enable_fifo),
      .Write_Enable_fifo (Write_Enable_fifo),
      .I_dec             (I_dec),
      .Q_dec             (Q_dec),
      .status_reg        (status_reg)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int src_i[$], src_q[$], sb_i[$], sb_q[$], wr_cyc[$];
   int cyc = 0, n_wr = 0, n_rd = 0, n_se = 0, n_sa = 0, n_both = 0, done_cyc = -1;
   bit re_prev = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Monitor: counts strobes/stalls per cycle and checks every write against the scoreboard.
   initial forever begin
      @(negedge clk);
      cyc++;
      re_prev = Read_Enable_fifo;
      if (Read_Enable_fifo) n_rd++;
      if (status_reg[2]) n_se++;
      if (status_reg[3]) n_sa++;
      if (Read_Enable_fifo && Write_Enable_fifo) n_both++;
      if (status_reg[0] && cyc >= 1 && done_cyc < 0) done_cyc = cyc;
      if (Write_Enable_fifo) begin
         n_wr++;
         wr_cyc.push_back(cyc);
         if (sb_i.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            chk("i_dec", int'($signed(I_dec)), sb_i.pop_front());
            chk("q_dec", int'($signed(Q_dec)), sb_q.pop_front());
         end
      end
   end

   // Upstream FIFO model: data appears one cycle after a read strobe.
   initial forever begin
      @(posedge clk);
      #1;
      if (re_prev && src_i.size() > 0) begin
         data_in_I = W'(src_i.pop_front());
         data_in_Q = W'(src_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic grp(input int i0, i1, i2, i3, q0, q1, q2, q3);
      src_i.push_back(i0); src_i.push_back(i1); src_i.push_back(i2); src_i.push_back(i3);
      src_q.push_back(q0); src_q.push_back(q1); src_q.push_back(q2); src_q.push_back(q3);
      sb_i.push_back((i0 + i1 + i2 + i3) >>> 2);
      sb_q.push_back((q0 + q1 + q2 + q3) >>> 2);
   endtask

   task automatic smp(input int i, input int q);
      src_i.push_back(i); src_q.push_back(q);
      sb_i.push_back(i);  sb_q.push_back(q);
   endtask

   // Pulses start in cycle 0; returns at the start of cycle 1.
   task automatic go(input int num, input bit byp);
      config_reg = {15'h0, byp, num[15:0]};
      start = 1'b1;
      cyc = -1; n_wr = 0; n_rd = 0; n_se = 0; n_sa = 0; done_cyc = -1;
      wr_cyc.delete();
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int k;
      k = 0;
      while (!status_reg[0] && k < lim) begin
         tick();
         k++;
      end
      chk("done_reached", int'(status_reg[0]), 1);
      tick();
   endtask

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_i_dec", int'(I_dec), 0);
      chk("rst_q_dec", int'(Q_dec), 0);
      chk("rst_status", int'(status_reg), 0);
      chk("rst_strobes", int'({Read_Enable_fifo, Write_Enable_fifo}), 0);
      rst_a = 1'b0;
      tick(); tick(); tick();
      chk("idle_no_action", n_rd + n_wr + int'(status_reg), 0);

      // Basic average with exact cycle timing
      grp(100, 104, 108, 112, -1, -1, -1, -2);
      go(1, 1'b0);
      chk("busy_run", int'(status_reg[1]), 1);
      wait_done(20);
      chk("t1_writes", n_wr, 1);
      chk("t1_wr_cyc", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 6);
      chk("t1_done_cyc", done_cyc, 8);
      chk("t1_reads", n_rd, 4);
      chk("t1_busy_after", int'(status_reg[1]), 0);

      // Full-scale extremes
      grp(2047, 2047, 2047, 2047, -2048, -2048, -2048, -2048);
      grp(-2048, -2048, -2048, -2048, 2047, 2047, 2047, 2047);
      go(2, 1'b0);
      chk("t2_done_cleared", int'(status_reg[0]), 0);
      wait_done(40);
      chk("t2_writes", n_wr, 2);
      chk("t2_wr_cyc1", (wr_cyc.size() > 1) ? wr_cyc[1] : -1, 12);

      // Upstream empty stall of 5 cycles after the second read
      grp(3, 5, -7, 20, -3, -5, 7, -20);
      go(1, 1'b0);
      tick();
      tick();
      Empty_i = 1'b1;
      repeat (5) tick();
      Empty_i = 1'b0;
      wait_done(40);
      chk("t3_stop_empty", n_se, 5);
      chk("t3_wr_cyc", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 11);
      chk("t3_reads", n_rd, 4);

      // Downstream almost-full stall, plus an ignored start/config change mid-run
      grp(-1, -2, -3, -4, 9, 9, 9, 8);
      go(1, 1'b0);
      repeat (5) tick();
      Afull_i = 1'b1;
      tick();
      config_reg = 32'h0001_0005;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t4_hold_i", int'($signed(I_dec)), -3);
      chk("t4_hold_q", int'($signed(Q_dec)), 8);
      chk("t4_no_write", int'(Write_Enable_fifo), 0);
      chk("t4_byp_unchanged", int'(status_reg[5]), 0);
      tick();
      Afull_i = 1'b0;
      wait_done(40);
      chk("t4_stop_afull", n_sa, 3);
      chk("t4_wr_cyc", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 9);
      chk("t4_writes", n_wr, 1);

      // Bypass, then a zero-length run
      smp(5, -1);
      smp(-7, 0);
      smp(9, 2047);
      go(3, 1'b1);
      chk("t5_bypass_bit", int'(status_reg[5]), 1);
      wait_done(40);
      chk("t5_writes", n_wr, 3);
      chk("t5_reads", n_rd, 3);
      for (int k = 0; k < 3; k++)
         chk("t5_wr_cyc", (wr_cyc.size() > k) ? wr_cyc[k] : -1, 3 * (k + 1));
      go(0, 1'b0);
      wait_done(10);
      chk("t6_strobes", n_rd + n_wr, 0);
      chk("t6_done_cyc", done_cyc, 2);

      // Reset mid-READ after two reads, then a clean run
      grp(10, 20, 30, 40, 1, 1, 1, 1);
      go(1, 1'b0);
      tick();
      tick();
      #2;
      rst_a = 1'b1;
      src_i.delete(); src_q.delete(); sb_i.delete(); sb_q.delete();
      #1;
      chk("t7_rst_status", int'(status_reg), 0);
      chk("t7_rst_strobes", int'({Read_Enable_fifo, Write_Enable_fifo}), 0);
      chk("t7_rst_out", int'({I_dec, Q_dec}), 0);
      tick();
      rst_a = 1'b0;
      tick();
      grp(-8, -9, -10, -11, 1, 2, 3, 4);
      go(1, 1'b0);
      wait_done(40);
      chk("t7_writes", n_wr, 1);
      chk("t7_reads", n_rd, 4);

      chk("rd_wr_overlap", n_both, 0);
      chk("sb_leftover", sb_i.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/decim4_d4_core.md
DECIM4_D4_CORE -- requirements
Module: decim4_d4_core

Interface
REQ-001 SHALL have parameter DATAPATH_WIDTH, default 12, sample width in two's complement.
REQ-002 SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have input rst_a, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have input start, 1 bit, single-cycle start pulse.
REQ-005 SHALL have input Empty_i, 1 bit, high when either upstream I/Q FIFO is empty.
REQ-006 SHALL have input Afull_i, 1 bit, high when either downstream FIFO is almost full.
REQ-007 SHALL have input config_reg, 32 bits: [15:0] num_out (output samples per run), [16] bypass; other bits ignored.
REQ-008 SHALL have inputs data_in_I and data_in_Q, DATAPATH_WIDTH each, upstream FIFO outputs, valid one cycle after Read_Enable_fifo.
REQ-009 SHALL have output Read_Enable_fifo, 1 bit, shared I/Q read strobe.
REQ-010 SHALL have output Write_Enable_fifo, 1 bit, downstream write strobe.
REQ-011 SHALL have outputs I_dec and Q_dec, DATAPATH_WIDTH each, registered decimated samples.
REQ-012 SHALL have output status_reg, 8 bits: [0] done, [1] busy, [2] stop_empty, [3] stop_afull, [5] bypass, others 0.

Function
REQ-013 SHALL implement states IDLE, READ, OUT, DONE.
REQ-014 IDLE: start=1 SHALL latch config_reg, clear output counter, accumulators, done, and go to READ next cycle; num_out=0 SHALL go to DONE instead.
REQ-015 READ: Read_Enable_fifo SHALL equal !Empty_i while fewer than K reads issued in current group (K=4, or 1 when bypass latched).
REQ-016 Each input SHALL be captured in the cycle after its Read_Enable_fifo pulse and sign-extended into DATAPATH_WIDTH+2-bit accumulators, one per channel.
REQ-017 On the capture of the K-th sample, I_dec/Q_dec SHALL load (acc + sample) arithmetically shifted right by 2 (bypass: sample unchanged), accumulators SHALL clear, and state SHALL go to OUT.
REQ-018 Arithmetic shift SHALL truncate toward minus infinity; the result always fits DATAPATH_WIDTH, no saturation needed.
REQ-019 OUT: Write_Enable_fifo SHALL equal !Afull_i; on a write cycle the output counter SHALL increment and state SHALL go to READ, or to DONE if counter reaches num_out.
REQ-020 I_dec/Q_dec SHALL hold stable throughout OUT, including Afull_i stalls.
REQ-021 Latency without stalls: start at cycle 0, reads cycles 1-4, outputs loaded at end of cycle 5, Write_Enable_fifo high in cycle 6; 6 cycles per output (3 in bypass).
REQ-022 stop_empty SHALL be high in READ cycles where a read is pending and Empty_i=1; stop_afull SHALL be high in OUT cycles with Afull_i=1.
REQ-023 busy SHALL be high in READ and OUT; bypass bit SHALL reflect the latched bypass.
REQ-024 DONE: done SHALL be set (sticky) and state SHALL return to IDLE next cycle; done SHALL clear only on next accepted start or reset.
REQ-025 start while busy SHALL be ignored; config_reg changes mid-run SHALL have no effect.
REQ-026 Read_Enable_fifo and Write_Enable_fifo SHALL never both be high in the same cycle.

Reset
REQ-027 rst_a=1 SHALL immediately force IDLE and zero all outputs, accumulators, counters, and status_reg, including mid-run; pending captures are discarded.
REQ-028 After rst_a deasserts, the block SHALL take no action until start.

Verification
REQ-029 num_out=1, I inputs 100,104,108,112, Q inputs -1,-1,-1,-2, no stalls -> one write in cycle 6 with I_dec=106, Q_dec=-2; done=1 in cycle 8.
REQ-030 Four inputs 2047 then four inputs -2048, num_out=2 -> outputs 2047 then -2048, exactly two Write_Enable_fifo pulses.
REQ-031 Empty_i=1 for 5 cycles after second read -> Read_Enable_fifo low and stop_empty=1 those cycles; result unchanged, write delayed 5 cycles.
REQ-032 Afull_i=1 for 3 cycles in OUT -> no write, stop_afull=1, I_dec stable; write in first cycle Afull_i=0.
REQ-033 bypass=1, num_out=3, inputs 5,-7,9 -> outputs 5,-7,9, writes 3 cycles apart; num_out=0 -> done without any FIFO strobe.
REQ-034 rst_a pulsed during READ after 2 reads -> all outputs 0, IDLE; a new start with 4 fresh samples yields their correct average.
